// File: rtl/mac_requant.sv
// Requantizer: turns finished int/fp accumulator results into 16-bit activations through a
// 2-stage valid/ready pipeline. Build option MAC_REQUANT_ROUND_EN enables fp round-to-nearest-even.
module mac_requant (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mode,
    input  logic [23:0] acc_int,
    input  logic [4:0]  int_shift,
    input  logic [30:0] acc_fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_value,
    output logic [15:0] sat_cnt,
    output logic [15:0] flush_cnt,
    input  logic        clr_cnt
);

`ifdef MAC_REQUANT_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    // Handshake: a beat moves on a port in any cycle where valid && ready; a stage refills
    // in the same cycle it drains, so the pipeline sustains one beat per cycle.

    // ---------------- stage 0: shift / normalize / round (combinational) ----------------
    logic               in_is_fp;
    logic [4:0]         sh_eff;
    logic signed [23:0] r_in;
    logic [4:0]         e_in;
    logic [25:0]        m_in;
    logic               m_pos;
    logic [4:0]         lead_pos;
    logic [23:0]        norm;
    logic [6:0]         exp_norm;
    logic               round_up;
    logic [12:0]        frac_sum;
    logic [6:0]         exp_rnd;
    logic [11:0]        frac_rnd;
    logic               in_sat;
    logic               in_flush;
    logic               accept;

    assign in_is_fp = (mode == 2'b00);
    assign sh_eff   = (int_shift > 5'd23) ? 5'd23 : int_shift;
    assign r_in     = $signed(acc_int) >>> sh_eff;
    assign e_in     = acc_fp[30:26];
    assign m_in     = acc_fp[25:0];
    assign m_pos    = !m_in[25] && (|m_in[24:0]);

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < 25; i++) begin
            if (m_in[i]) lead_pos = 5'(i);
        end
    end

    // Left-justify the mantissa so the leading one lands at bit 24; the 12 fraction bits,
    // guard and sticky then sit at fixed positions and short mantissas are zero-filled.
    assign norm     = 24'(m_in[24:0] << (5'd24 - lead_pos));
    assign exp_norm = {{2{e_in[4]}}, e_in} - {2'b00, 5'd24 - lead_pos};
    assign round_up = ROUND_EN & norm[11] & ((|norm[10:0]) | norm[12]);
    assign frac_sum = {1'b0, norm[23:12]} + {12'd0, round_up};
    assign exp_rnd  = frac_sum[12] ? exp_norm + 7'd1 : exp_norm;
    assign frac_rnd = frac_sum[11:0];

    function automatic logic sat_hit(input logic is_fp, input logic pos,
                                     input logic [6:0] ex, input logic signed [23:0] r);
        logic hit;
        if (is_fp) hit = pos && ($signed(ex) > 7);
        else       hit = (r > 24'sd255);
        return hit;
    endfunction

    function automatic logic [15:0] encode(input logic is_fp, input logic pos,
                                           input logic [6:0] ex, input logic [11:0] f,
                                           input logic signed [23:0] r);
        logic [15:0] v;
        v = 16'h0000;
        if (!is_fp) begin
            if (r <= 24'sd0)        v = 16'h0000;
            else if (r > 24'sd255)  v = 16'h00FF;
            else                    v = {8'h00, r[7:0]};
        end else if (pos) begin
            if ($signed(ex) > 7)         v = 16'h7FFF;
            else if ($signed(ex) < -8)   v = 16'h0000;
            else if ({ex[3:0], f} == 16'h0000) v = 16'h0001;  // keep nonzero results off the zero code
            else                         v = {ex[3:0], f};
        end
        return v;
    endfunction

    assign in_sat   = sat_hit(in_is_fp, m_pos, exp_rnd, r_in);
    assign in_flush = in_is_fp && m_pos && ($signed(exp_rnd) < -8);

    // ---------------- pipeline control ----------------
    logic               s1_valid;
    logic               s1_is_fp;
    logic               s1_pos;
    logic [6:0]         s1_exp;
    logic [11:0]        s1_frac;
    logic signed [23:0] s1_r;
    logic               s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_is_fp  <= 1'b0;
            s1_pos    <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_r      <= '0;
            out_valid <= 1'b0;
            out_value <= 16'h0000;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_is_fp <= in_is_fp;
                    s1_pos   <= m_pos;
                    s1_exp   <= exp_rnd;
                    s1_frac  <= frac_rnd;
                    s1_r     <= r_in;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) out_value <= encode(s1_is_fp, s1_pos, s1_exp, s1_frac, s1_r);
            end
        end
    end

    // Clamp statistics are booked when the beat enters stage 1; clear wins over a same-cycle hit.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            sat_cnt   <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else if (accept) begin
            if (in_sat && (sat_cnt != 16'hFFFF))     sat_cnt   <= sat_cnt + 16'd1;
            if (in_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant: directed corner beats, backpressure, reset/clear and
// randomized traffic scored against an arithmetic reference model.
module tb_mac_requant;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [23:0] acc_int;
  logic [4:0]  int_shift;
  logic [30:0] acc_fp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic [15:0] sat_cnt;
  logic [15:0] flush_cnt;
  logic        clr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  int exp_sat   = 0;
  int exp_flush = 0;
  logic        held = 1'b0;
  logic [15:0] held_val = 16'h0000;
  logic        rnd_on = 1'b0;

`ifdef MAC_REQUANT_ROUND_EN
  localparam logic [15:0] RND_EXP = 16'h1002;
`else
  localparam logic [15:0] RND_EXP = 16'h1001;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mac_requant dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .acc_int   (acc_int),
    .int_shift (int_shift),
    .acc_fp    (acc_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .sat_cnt   (sat_cnt),
    .flush_cnt (flush_cnt),
    .clr_cnt   (clr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {sat, flush, value} from plain integer arithmetic.
  function automatic logic [17:0] ref_beat(input logic [1:0] md, input logic [23:0] ai,
                                           input logic [4:0] sh, input logic [30:0] af);
    longint mv, frac, num, q, rem, f;
    int p, ex, a, s, r, val;
    logic g, st;
    if (md != 2'b00) begin
      a = $signed(ai);
      s = (sh > 5'd23) ? 23 : int'(sh);
      r = a / (1 << s);
      if (r <= 0) return 18'h0;
      if (r > 255) return {2'b10, 16'h00FF};
      return {2'b00, 16'(r)};
    end
    mv = $signed(af[25:0]);
    ex = $signed(af[30:26]);
    if (mv <= 0) return 18'h0;
    p = 0;
    while ((mv >> (p + 1)) != 0) p++;
    frac = mv - (64'sd1 << p);
    num  = frac << 14;
    q    = num >> p;
    rem  = num - (q << p);
    f    = q >> 2;
    g    = ((q >> 1) & 1) != 0;
    st   = ((q & 1) != 0) || (rem != 0);
    ex   = ex - (24 - p);
`ifdef MAC_REQUANT_ROUND_EN
    if (g && (st || ((f & 1) != 0))) f = f + 1;
    if (f == 4096) begin
      f  = 0;
      ex = ex + 1;
    end
`endif
    if (ex > 7) return {2'b10, 16'h7FFF};
    if (ex < -8) return {2'b01, 16'h0000};
    val = ((ex & 15) << 12) | int'(f);
    if (val == 0) val = 1;
    return {2'b00, 16'(val)};
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  // dir[16] set: score the beat against dir[15:0] instead of the model value.
  task automatic send(input logic [1:0] md, input logic [23:0] ai, input logic [4:0] sh,
                      input logic [30:0] af, input logic [16:0] dir);
    logic [17:0] rb;
    int waited;
    mode = md; acc_int = ai; int_shift = sh; acc_fp = af; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    rb = ref_beat(md, ai, sh, af);
    if (clr_cnt) begin
      exp_sat = 0;
      exp_flush = 0;
    end else begin
      if (rb[17] && exp_sat < 65535) exp_sat++;
      if (rb[16] && exp_flush < 65535) exp_flush++;
    end
    exp_q.push_back(dir[16] ? dir[15:0] : rb[15:0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && out_valid) begin
      if (out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_value", 32'(out_value), 32'(e));
        end
      end else begin
        if (held) check("hold_stable", 32'(out_value), 32'(held_val));
        held = 1'b1;
        held_val = out_value;
      end
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  md;
    logic [23:0] ai;
    logic [4:0]  sh;
    logic [4:0]  ee;
    logic [25:0] mm;
    int width;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    mode = 2'b00; acc_int = '0; int_shift = '0; acc_fp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_sat_cnt",   32'(sat_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // integer clamp
    send(2'b01, 24'd300, 5'd0, 31'd0, {1'b1, 16'h00FF});
    send(2'b01, 24'd1000, 5'd2, 31'd0, {1'b1, 16'h00FA});
    send(2'b01, 24'hFFFF00, 5'd0, 31'd0, {1'b1, 16'h0000});
    drain();
    check("int_sat_cnt", 32'(sat_cnt), 32'd1);

    // fp normal, clamp, zero-code, rounding
    send(2'b00, 24'd0, 5'd0, {5'd2, 26'h1800000}, {1'b1, 16'h2800});
    send(2'b00, 24'd0, 5'd0, {5'd3, 26'h0400000}, {1'b1, 16'h1000});
    send(2'b00, 24'd0, 5'd0, {5'd9, 26'h1000000}, {1'b1, 16'h7FFF});
    send(2'b00, 24'd0, 5'd0, {5'h10, 26'h1000000}, {1'b1, 16'h0000});
    send(2'b00, 24'd0, 5'd0, {5'd0, 26'h1000000}, {1'b1, 16'h0001});
    send(2'b00, 24'd0, 5'd0, {5'd1, 26'h1001800}, {1'b1, RND_EXP});
    send(2'b00, 24'd0, 5'd0, {5'd4, 26'h3FFFFFF}, {1'b1, 16'h0000});
    drain();
    check("fp_sat_cnt",   32'(sat_cnt), 32'd2);
    check("fp_flush_cnt", 32'(flush_cnt), 32'd1);

    // backpressure: two beats fill the pipe, the third waits
    out_ready = 1'b0;
    send(2'b01, 24'd17, 5'd0, 31'd0, 17'h0);
    send(2'b10, 24'd400, 5'd1, 31'd0, 17'h0);
    fork
      send(2'b00, 24'd0, 5'd0, {5'd1, 26'h0C00000}, 17'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_sat_cnt", 32'(sat_cnt), 32'(exp_sat));

    // clear wins over a same-cycle clamp
    clr_cnt = 1'b1;
    send(2'b01, 24'd300, 5'd0, 31'd0, {1'b1, 16'h00FF});
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_sat_cnt", 32'(sat_cnt), 32'd0);
    check("clr_sat_model", 32'(sat_cnt), 32'(exp_sat));
    @(posedge clk);
    #1;
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(2'b01, 24'd999, 5'd0, 31'd0, 17'h0);
    send(2'b00, 24'd0, 5'd0, {5'h10, 26'h0100000}, 17'h0);
    rst = 1'b1;
    exp_q.delete();
    exp_sat = 0;
    exp_flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sat_cnt",   32'(sat_cnt), 32'd0);
    check("mid_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b11, 24'd77, 5'd0, 31'd0, {1'b1, 16'h004D});
    drain();

    // randomized traffic with random backpressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      md = 2'($urandom_range(0, 3));
      ai = ($urandom_range(0, 1) != 0) ? 24'($urandom_range(0, 2000)) : 24'($urandom);
      sh = 5'($urandom_range(0, 31));
      ee = 5'($urandom);
      width = $urandom_range(0, 26);
      mm = 26'($urandom) & 26'((64'd1 << width) - 1);
      if ($urandom_range(0, 3) == 0) mm = -mm;
      send(md, ai, sh, {ee, mm}, 17'h0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("rand_sat_cnt",   32'(sat_cnt), 32'(exp_sat));
    check("rand_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mac_requant.md
# mac_requant

Output-side requantizer for the quantized MAC datapath. It takes finished accumulator results, either a 24-bit integer accumulator or a 31-bit {exponent, signed mantissa} float accumulator, and re-encodes them into the 16-bit activation ("value") format that the MAC consumes on its next pass. It applies ReLU, normalization, rounding and saturation. It sits between the accumulator registers and the activation buffer as a 2-stage valid/ready pipeline, and keeps clamp statistics.

## Interface
- No parameters.
- `clk` input 1: clock; all state changes on rising edge.
- `rst` input 1: synchronous active-high reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: input beat accepted when `in_valid && in_ready`.
- `mode` input 2: per beat. 00 = fp, 01 = int_s, 10 = int_m, 11 = int_l.
- `acc_int` input 24: signed integer accumulator; used in int modes.
- `int_shift` input 5: arithmetic right shift applied to `acc_int`, range 0..23; values of 24 or more are treated as 23.
- `acc_fp` input 31: {e[30:26] signed, m[25:0] signed}; used in fp mode.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_value` output 16: encoded activation.
- `sat_cnt` output 16: count of overflow clamps; saturates at 16'hFFFF.
- `flush_cnt` output 16: count of fp underflow flushes; saturates at 16'hFFFF.
- `clr_cnt` input 1: synchronous clear of both counters.

## Operation
- **Int modes** (01, 10 and 11 are identical here):
  - r = acc_int >>> int_shift.
  - If r ≤ 0, out_value = 16'h0000.
  - If r > 255, out_value = 16'h00FF and sat_cnt increments.
  - Otherwise out_value = {8'h00, r[7:0]}.
- **fp mode**, ReLU: if m ≤ 0, out_value = 16'h0000 and no counter changes.
- **fp mode**, normalization:
  - p = index of the leading one of m, in 0..24.
  - E = e − (24 − p), computed at 7-bit signed width.
  - f = the 12 bits of m directly below bit p, zero-filled when p < 12.
  - guard = the bit below f; sticky = OR of all remaining lower bits.
- **Rounding**: performed per the Configuration section. If f rounds up past 12'hFFF, f becomes 0 and E increments by 1.
- **Clamp**:
  - E > 7: out_value = 16'h7FFF and sat_cnt increments.
  - E < −8: out_value = 16'h0000 and flush_cnt increments.
  - Otherwise out_value = {E[3:0], f}.
- **Zero-code collision**: the MAC treats 16'h0000 as zero. A nonzero fp result that would encode to 16'h0000 (E = 0, f = 0) is emitted as 16'h0001.
- **Counters**:
  - Counters update when the affected beat is accepted into stage 1.
  - clr_cnt has priority over an increment in the same cycle.

## Timing
- Stage 1 registers the shift/leading-one result. Stage 2 registers the rounded, clamped `out_value`.
- Latency: 2 cycles from input handshake to `out_valid`, with `out_ready` held high.
- Throughput: 1 beat per cycle.
- Stage advance rules:
  - Stage 2 advances when `!out_valid || out_ready`.
  - Stage 1 advances when stage 2 advances or stage 2 is empty.
  - `in_ready` = stage 1 empty, or stage 1 advancing. It is combinational; no bubble is required.
- While `out_valid && !out_ready`, `out_value` holds stable. At most 2 beats are stored; no beat is dropped or reordered.
- Simultaneous input accept and output pop in the same cycle is legal and preserves throughput.
- Reset values:
  - `out_valid` = 0, `out_value` = 16'h0000, `sat_cnt` = 0, `flush_cnt` = 0.
  - Both stage-valid bits are 0, so `in_ready` = 1.
- Reset mid-operation discards all in-flight beats and clears both counters in the same cycle.
- Outputs are undefined-free: stage data registers reset to 0.

## Configuration
- `MAC_REQUANT_ROUND_EN` defined: fp rounds to nearest even.
  - Round up if guard && (sticky || f[0]).
  - Int results are not rounded.
- `MAC_REQUANT_ROUND_EN` undefined: fp truncates; guard and sticky are ignored.
- Latency and handshake are identical in both builds.

## Test plan
- **Int clamp**: mode 01, acc_int = 300, shift 0 → 16'h00FF, sat_cnt = 1. Then acc_int = 1000, shift 2 → 16'h00FA. Then acc_int = 24'hFFFF00 → 16'h0000.
- **fp normal**: e = 2, m = 26'h1800000 → 16'h2800. Unnormalized input e = 3, m = 26'h0400000 → 16'h1000.
- **fp clamp**: e = 9, m = 26'h1000000 → 16'h7FFF, sat_cnt increments. e = 5'h10 (−16), m = 26'h1000000 → 16'h0000, flush_cnt increments. e = 0, m = 26'h1000000 → 16'h0001.
- **Rounding**: e = 1, m = 26'h1001800 → 16'h1002 with the macro defined; 16'h1001 without it.
- **Backpressure**: 3 back-to-back beats with out_ready low for 5 cycles.
  - in_ready drops after 2 beats are accepted.
  - out_value is stable throughout.
  - All 3 results emerge in order after out_ready rises.
- **Reset/clear**:
  - Assert rst while 2 beats are in flight → out_valid = 0 next cycle, counters = 0.
  - clr_cnt asserted together with a clamping beat → sat_cnt = 0.
